// File: rtl/nv_nvdla_sdp_wdma_cmd_sfifo_ctrl.sv
// Control logic for the SDP WDMA command sync FIFO: drives an external 4-entry flop RAM
// and a registered output stage, with flow-through via RAM read address DEPTH when empty.
module nv_nvdla_sdp_wdma_cmd_sfifo_ctrl #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [31:0]      pwrbus_ram_pd,
    input  logic             wr_req,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic [AW:0]      ram_ra,
    input  logic [WIDTH-1:0] ram_dout
);

    // Valid/ready: a beat transfers on a rising clock edge where both valid
    // (wr_req / rd_valid) and ready (wr_ready / rd_ready) are high; rd_valid and
    // rd_pd stay stable until the beat is taken.

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          ram_empty;
    logic          ram_full;
    logic          wr_acc;
    logic          out_ld;
    logic          pop;
    logic          bypass;
    logic          unused_pwrbus;

    // Power bus only matters to the storage macro.
    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign ram_empty = (ram_cnt == '0);
    assign ram_full  = (ram_cnt == CNT_FULL);

    // Held low during reset so nothing is accepted while state is being cleared.
    assign wr_ready = ~nvdla_core_rst & ~ram_full;
    assign wr_acc   = wr_req & wr_ready;

    assign out_ld = ~rd_valid | rd_ready;
    assign pop    = out_ld & ~ram_empty;
    assign bypass = out_ld & ram_empty & wr_acc;

    // Bypass only when RAM is empty, so the flow-through word can never overtake stored ones.
    assign ram_ra = bypass ? CNT_FULL : {1'b0, rd_ptr};
    assign ram_we = wr_acc & ~bypass;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_pd    <= '0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({ram_we, pop})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
            if (out_ld) begin
                if (pop | bypass) begin
                    rd_pd    <= ram_dout;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end
    end

endmodule
